// File: rtl/c_element_array.sv
// ---------------------------------------------------------------------------
// c_element_array
//
// Clocked array of N_CH generalised Muller C-elements with N_IN inputs each.
// Every input position is symmetric, plus-only (counts only towards setting)
// or minus-only (counts only towards resetting). Each channel has a registered
// output, one-cycle rise/fall pulses and a stall watchdog that flags a channel
// that has sat half-way through a transition for too long.
//
// Ports
//   clk      in   1          clock, all state updates on the rising edge
//   rst_n    in   1          synchronous reset, active low
//   in_i     in   N_CH*N_IN  channel c inputs are in_i[c*N_IN +: N_IN]
//   s_o      out  N_CH       registered C-element outputs
//   rise_o   out  N_CH       one-cycle pulse in the first cycle s_o[c] reads 1
//   fall_o   out  N_CH       one-cycle pulse in the first cycle s_o[c] reads 0
//   stall_o  out  N_CH       channel pending for at least STALL_CYC cycles
// ---------------------------------------------------------------------------
module c_element_array #(
  parameter int              N_CH       = 4,
  parameter int              N_IN       = 2,
  parameter logic [N_CH-1:0] INIT       = '0,
  parameter logic [N_IN-1:0] PLUS_MASK  = '0,
  parameter logic [N_IN-1:0] MINUS_MASK = '0,
  parameter int              STALL_CYC  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH*N_IN-1:0] in_i,
  output logic [N_CH-1:0]      s_o,
  output logic [N_CH-1:0]      rise_o,
  output logic [N_CH-1:0]      fall_o,
  output logic [N_CH-1:0]      stall_o
);

  // A watchdog of 0 cycles is disabled, but the counter still needs one bit.
  localparam int              CW       = (STALL_CYC > 0) ? $clog2(STALL_CYC + 1) : 1;
  localparam logic [CW-1:0]   CNT_MAX  = CW'(STALL_CYC);
  localparam logic            STALL_EN = (STALL_CYC != 0);

  // Inputs that take part in the falling condition (everything not plus-only).
  localparam logic [N_IN-1:0] RST_USE  = ~PLUS_MASK;
  // Inputs that take part in the rising condition (everything not minus-only).
  localparam logic [N_IN-1:0] SET_USE  = ~MINUS_MASK;

  // Parameter legality, reported at elaboration time.
  if ((PLUS_MASK & MINUS_MASK) != '0) begin : g_err_overlap
    $error("c_element_array: PLUS_MASK and MINUS_MASK overlap");
  end
  if ((PLUS_MASK | MINUS_MASK) == {N_IN{1'b1}}) begin : g_err_no_sym
    $error("c_element_array: at least one symmetric input is required");
  end
  if (N_IN < 2) begin : g_err_n_in
    $error("c_element_array: N_IN must be at least 2");
  end
  if (N_CH < 1) begin : g_err_n_ch
    $error("c_element_array: N_CH must be at least 1");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [N_IN-1:0] v;
    logic            setc;
    logic            rstc;
    logic            pending;
    logic            s_q;
    logic            s_next;
    logic            rise_q;
    logic            rise_next;
    logic            fall_q;
    logic            fall_next;
    logic            stall_q;
    logic            stall_next;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_next;

    assign v = in_i[c*N_IN +: N_IN];

    // Minus-only positions are forced to 1 for the set test and plus-only
    // positions are masked off for the reset test, so each reduction only
    // sees the inputs that take part in that direction.
    always_comb begin
      setc       = &(v | MINUS_MASK);
      rstc       = ~|(v & RST_USE);
      pending    = 1'b0;
      s_next     = s_q;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      cnt_next   = '0;
      stall_next = 1'b0;

      // Pending means the inputs have started moving towards the opposite
      // state but have not all arrived yet.
      if (s_q) begin
        pending   = (|(~v & RST_USE)) & ~rstc;
        s_next    = ~rstc;
        fall_next = rstc;
      end else begin
        pending   = (|(v & SET_USE)) & ~setc;
        s_next    = setc;
        rise_next = setc;
      end

      // The stall flag looks at the count before this cycle's increment, so
      // it asserts on the first pending sample after the counter saturated
      // and drops together with the counter once pending clears.
      if (pending) begin
        cnt_next   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        stall_next = STALL_EN & (cnt_q == CNT_MAX);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s_q     <= INIT[c];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        stall_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s_q     <= s_next;
        rise_q  <= rise_next;
        fall_q  <= fall_next;
        stall_q <= stall_next;
        cnt_q   <= cnt_next;
      end
    end

    assign s_o[c]     = s_q;
    assign rise_o[c]  = rise_q;
    assign fall_o[c]  = fall_q;
    assign stall_o[c] = stall_q;
  end

endmodule

// File: tb/tb_c_element_array.sv
// ---------------------------------------------------------------------------
// tb_c_element_array
//
// Drives three differently parameterised c_element_array instances from
// directed sequences followed by a long random run. A per-channel behavioural
// model tracks what each output must be; a negedge process compares all
// outputs against it every cycle, and the directed sections add literal
// hand-computed expectations.
//   dut 0: N_IN=2, INIT=0101, no masks,              STALL_CYC=4
//   dut 1: N_IN=3, INIT=0000, PLUS=100,  MINUS=000,  STALL_CYC=2
//   dut 2: N_IN=3, INIT=1010, PLUS=001,  MINUS=100,  STALL_CYC=0
// ---------------------------------------------------------------------------
module tb_c_element_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_a;
  logic [11:0] in_b;
  logic [11:0] in_c;

  logic [3:0]  d_s     [3];
  logic [3:0]  d_rise  [3];
  logic [3:0]  d_fall  [3];
  logic [3:0]  d_stall [3];

  int n_vec = 0;
  int n_err = 0;
  bit model_live = 1'b0;

  // Model state per instance and channel
  logic [3:0] m_s     [3];
  logic [3:0] m_rise  [3];
  logic [3:0] m_fall  [3];
  logic [3:0] m_stall [3];
  int         m_run   [3][4];

  always #5 clk = ~clk;

  c_element_array #(
    .N_CH(4), .N_IN(2), .INIT(4'b0101),
    .PLUS_MASK(2'b00), .MINUS_MASK(2'b00), .STALL_CYC(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_a),
    .s_o(d_s[0]), .rise_o(d_rise[0]), .fall_o(d_fall[0]), .stall_o(d_stall[0])
  );

  c_element_array #(
    .N_CH(4), .N_IN(3), .INIT(4'b0000),
    .PLUS_MASK(3'b100), .MINUS_MASK(3'b000), .STALL_CYC(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_i(in_b),
    .s_o(d_s[1]), .rise_o(d_rise[1]), .fall_o(d_fall[1]), .stall_o(d_stall[1])
  );

  c_element_array #(
    .N_CH(4), .N_IN(3), .INIT(4'b1010),
    .PLUS_MASK(3'b001), .MINUS_MASK(3'b100), .STALL_CYC(0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .in_i(in_c),
    .s_o(d_s[2]), .rise_o(d_rise[2]), .fall_o(d_fall[2]), .stall_o(d_stall[2])
  );

  // Reference behaviour of one instance for one clock edge. Each channel is
  // judged from which of its inputs have reached the target level: all of
  // them means the output flips, some of them means the channel is waiting.
  // The stall flag is set once the current waiting streak is longer than the
  // watchdog limit.
  task automatic model_step(input int d, input logic [11:0] bus, input int n,
                            input logic [2:0] plus, input logic [2:0] minus,
                            input int stall_cyc);
    for (int c = 0; c < 4; c++) begin
      logic [2:0] v;
      int  up_cnt, up_need, dn_cnt, dn_need;
      bit  old_s, new_s, pend;
      v = 3'((bus >> (c * n)) & ((12'd1 << n) - 12'd1));
      up_cnt = 0; up_need = 0; dn_cnt = 0; dn_need = 0;
      for (int i = 0; i < n; i++) begin
        if (!minus[i]) begin
          up_need++;
          if (v[i]) up_cnt++;
        end
        if (!plus[i]) begin
          dn_need++;
          if (!v[i]) dn_cnt++;
        end
      end
      old_s = m_s[d][c];
      if (old_s) begin
        new_s = !(dn_cnt == dn_need);
        pend  = (dn_cnt > 0) && (dn_cnt < dn_need);
      end else begin
        new_s = (up_cnt == up_need);
        pend  = (up_cnt > 0) && (up_cnt < up_need);
      end
      m_rise[d][c] = !old_s && new_s;
      m_fall[d][c] = old_s && !new_s;
      if (pend) begin
        if (m_run[d][c] < 1000) m_run[d][c]++;
      end else begin
        m_run[d][c] = 0;
      end
      m_stall[d][c] = pend && (stall_cyc != 0) && (m_run[d][c] > stall_cyc);
      m_s[d][c] = new_s;
    end
  endtask

  // Model update on every rising edge, from the same inputs the DUTs sample.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_s[0] = 4'b0101;
      m_s[1] = 4'b0000;
      m_s[2] = 4'b1010;
      for (int d = 0; d < 3; d++) begin
        m_rise[d]  = 4'b0;
        m_fall[d]  = 4'b0;
        m_stall[d] = 4'b0;
        for (int c = 0; c < 4; c++) m_run[d][c] = 0;
      end
    end else begin
      model_step(0, {4'b0, in_a}, 2, 3'b000, 3'b000, 4);
      model_step(1, in_b,         3, 3'b100, 3'b000, 2);
      model_step(2, in_c,         3, 3'b001, 3'b100, 0);
    end
    model_live = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (model_live) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("model_s%0d", d),     d_s[d],     m_s[d]);
        checkOutput($sformatf("model_rise%0d", d),  d_rise[d],  m_rise[d]);
        checkOutput($sformatf("model_fall%0d", d),  d_fall[d],  m_fall[d]);
        checkOutput($sformatf("model_stall%0d", d), d_stall[d], m_stall[d]);
        checkOutput($sformatf("pulse_excl%0d", d),  d_rise[d] & d_fall[d], 4'b0000);
      end
    end
  end

  // Drive one set of inputs, let one rising edge sample them, then return
  // just after the edge so the caller sees the resulting outputs.
  task automatic applyStimulus(input logic r, input logic [7:0] a,
                               input logic [11:0] b, input logic [11:0] c);
    rst_n = r;
    in_a  = a;
    in_b  = b;
    in_c  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random inputs
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b0, 8'($urandom), 12'($urandom), 12'($urandom));
    checkOutput("t1_s",     d_s[0],     4'b0101);
    checkOutput("t1_rise",  d_rise[0],  4'b0000);
    checkOutput("t1_fall",  d_fall[0],  4'b0000);
    checkOutput("t1_stall", d_stall[0], 4'b0000);
    checkOutput("t1_s_b",   d_s[1],     4'b0000);
    checkOutput("t1_s_c",   d_s[2],     4'b1010);

    // Release with all inputs low: channels initialised to 1 fall
    applyStimulus(1'b1, 8'h00, 12'h000, 12'h000);
    checkOutput("rel_s",      d_s[0],    4'b0000);
    checkOutput("rel_fall",   d_fall[0], 4'b0101);
    checkOutput("rel_fall_c", d_fall[2], 4'b1010);
    applyStimulus(1'b1, 8'h00, 12'h000, 12'h000);
    checkOutput("rel_fall2",  d_fall[0], 4'b0000);

    // Channel 0 half-set for three cycles, then set, hold, reset
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'b0000_0001, 12'h000, 12'h000);
      checkOutput("t2_hold0", d_s[0], 4'b0000);
    end
    applyStimulus(1'b1, 8'b0000_0011, 12'h000, 12'h000);
    checkOutput("t2_set",   d_s[0],    4'b0001);
    checkOutput("t2_rise",  d_rise[0], 4'b0001);
    applyStimulus(1'b1, 8'b0000_0010, 12'h000, 12'h000);
    checkOutput("t2_hold1", d_s[0],    4'b0001);
    checkOutput("t2_rise2", d_rise[0], 4'b0000);
    applyStimulus(1'b1, 8'b0000_0000, 12'h000, 12'h000);
    checkOutput("t2_clr",   d_s[0],    4'b0000);
    checkOutput("t2_fall",  d_fall[0], 4'b0001);

    // Channel 1 stuck half-set: watchdog limit 4
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 8'b0000_1000, 12'h000, 12'h000);
      checkOutput("t4_nostall", d_stall[0], 4'b0000);
    end
    applyStimulus(1'b1, 8'b0000_1000, 12'h000, 12'h000);
    checkOutput("t4_stall5", d_stall[0], 4'b0010);
    applyStimulus(1'b1, 8'b0000_1000, 12'h000, 12'h000);
    checkOutput("t4_stall6", d_stall[0], 4'b0010);
    applyStimulus(1'b1, 8'b0000_1100, 12'h000, 12'h000);
    checkOutput("t4_set",     d_s[0],     4'b0010);
    checkOutput("t4_release", d_stall[0], 4'b0000);
    checkOutput("t4_rise",    d_rise[0],  4'b0010);
    applyStimulus(1'b1, 8'h00, 12'h000, 12'h000);
    checkOutput("t4_fall", d_fall[0], 4'b0010);

    // Plus-only bit 2 on dut 1: needed to set, ignored when resetting
    applyStimulus(1'b1, 8'h00, 12'b011, 12'h000);
    checkOutput("t3_noset", d_s[1],    4'b0000);
    applyStimulus(1'b1, 8'h00, 12'b111, 12'h000);
    checkOutput("t3_set",   d_s[1],    4'b0001);
    checkOutput("t3_rise",  d_rise[1], 4'b0001);
    applyStimulus(1'b1, 8'h00, 12'b011, 12'h000);
    checkOutput("t3_hold",  d_s[1],    4'b0001);
    applyStimulus(1'b1, 8'h00, 12'b100, 12'h000);
    checkOutput("t3_clr",   d_s[1],    4'b0000);
    checkOutput("t3_fall",  d_fall[1], 4'b0001);

    // All inputs high with a one-cycle reset pulse in the middle
    applyStimulus(1'b1, 8'hFF, 12'h000, 12'h000);
    applyStimulus(1'b1, 8'hFF, 12'h000, 12'h000);
    checkOutput("t5_pre",    d_s[0],     4'b1111);
    applyStimulus(1'b0, 8'hFF, 12'h000, 12'h000);
    checkOutput("t5_rst_s",  d_s[0],     4'b0101);
    checkOutput("t5_rst_r",  d_rise[0],  4'b0000);
    checkOutput("t5_rst_st", d_stall[0], 4'b0000);
    applyStimulus(1'b1, 8'hFF, 12'h000, 12'h000);
    checkOutput("t5_post_s", d_s[0],     4'b1111);
    checkOutput("t5_post_r", d_rise[0],  4'b1010);

    // Long random run with occasional resets, checked against the model
    for (int k = 0; k < 10000; k++) begin
      logic r;
      r = ($urandom_range(0, 299) != 0);
      applyStimulus(r, 8'($urandom), 12'($urandom), 12'($urandom));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
